// File: rtl/cpu6_pipestage_skid_pkg.sv
// Shared definitions for the cpu6 generic pipeline-stage register:
// occupancy state encoding and the default stall-counter width.
package cpu6_pipestage_skid_pkg;

  typedef enum logic [1:0] {
    CPU6_PS_EMPTY = 2'd0,
    CPU6_PS_ONE   = 2'd1,
    CPU6_PS_TWO   = 2'd2
  } cpu6_ps_state_e;

  localparam int unsigned CPU6_PS_CNT_W = 16;

  function automatic logic ps_has_data(input cpu6_ps_state_e s);
    return (s != CPU6_PS_EMPTY);
  endfunction

endpackage

// File: rtl/cpu6_pipestage_skid_satcnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module cpu6_satcnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/cpu6_pipestage_skid.sv
// Generic cpu6 pipeline-stage register: valid/ready payload slot with optional
// two-entry skid buffer (registered in_ready), flush, and a stall counter.
module cpu6_pipestage_skid
  import cpu6_pipestage_skid_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned SKID           = 1,
  parameter int unsigned CLEAR_ON_FLUSH = 1,
  parameter int unsigned CNT_W          = CPU6_PS_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  cpu6_ps_state_e   state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic             in_fire_s;
  logic             out_fire_s;

  assign out_valid  = ps_has_data(state_q);
  assign out_data   = main_q;
  // Skid mode: in_ready comes from a flop, only gated by reset.
  assign in_ready   = (SKID != 0) ? (rdy_q & ~reset)
                                  : (~reset & (~out_valid | out_ready));
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;

  // next occupancy state and payload registers
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = CPU6_PS_EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        main_d = '0;
        skid_d = '0;
      end else begin
        main_d = main_q;
        skid_d = skid_q;
      end
    end else if (SKID != 0) begin
      case (state_q)
        CPU6_PS_EMPTY: begin
          if (in_fire_s) begin
            state_d = CPU6_PS_ONE;
            main_d  = in_data;
          end else begin
            state_d = CPU6_PS_EMPTY;
          end
        end
        CPU6_PS_ONE: begin
          if (in_fire_s && out_fire_s) begin
            main_d = in_data;
          end else if (in_fire_s) begin
            state_d = CPU6_PS_TWO;
            skid_d  = in_data;
          end else if (out_fire_s) begin
            state_d = CPU6_PS_EMPTY;
          end else begin
            state_d = CPU6_PS_ONE;
          end
        end
        CPU6_PS_TWO: begin
          if (out_fire_s) begin
            state_d = CPU6_PS_ONE;
            main_d  = skid_q;
          end else begin
            state_d = CPU6_PS_TWO;
          end
        end
        default: begin
          state_d = CPU6_PS_EMPTY;
        end
      endcase
    end else begin
      // Single-register mode: a load always wins over a drain.
      if (in_fire_s) begin
        state_d = CPU6_PS_ONE;
        main_d  = in_data;
      end else if (out_fire_s) begin
        state_d = CPU6_PS_EMPTY;
      end else begin
        state_d = state_q;
      end
    end
    rdy_d = (state_d != CPU6_PS_TWO);
  end

  // state, payload and registered-ready flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CPU6_PS_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
    end
  end

  cpu6_satcnt #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (out_valid & ~out_ready & ~flush),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_cpu6_pipestage_skid.sv
// Bench for cpu6_pipestage_skid: a skid instance (A) and a single-register
// instance (B) share stimulus and are checked against a queue-based model.
module tb_cpu6_pipestage_skid;

  logic       clk = 1'b0;
  logic       rst, fl, iv, ordy;
  logic [7:0] id;

  logic       a_ir, a_ov, b_ir, b_ov;
  logic [7:0] a_od, b_od;
  logic [3:0] a_sc, b_sc;

  int checks = 0;
  int errors = 0;

  // model: per instance, an ordered list of held payloads and a stall count
  logic [7:0] mq [2][2];
  int         msz [2];
  int         mcnt [2];
  logic       mr [2];
  bit         model_on = 1'b0;

  always #5 clk = ~clk;

  cpu6_pipestage_skid #(.WIDTH(8), .SKID(1), .CLEAR_ON_FLUSH(1), .CNT_W(4)) u_a (
    .clk(clk), .reset(rst), .flush(fl), .in_valid(iv), .in_ready(a_ir),
    .in_data(id), .out_valid(a_ov), .out_ready(ordy), .out_data(a_od),
    .stall_cnt(a_sc));

  cpu6_pipestage_skid #(.WIDTH(8), .SKID(0), .CLEAR_ON_FLUSH(0), .CNT_W(4)) u_b (
    .clk(clk), .reset(rst), .flush(fl), .in_valid(iv), .in_ready(b_ir),
    .in_data(id), .out_valid(b_ov), .out_ready(ordy), .out_data(b_od),
    .stall_cnt(b_sc));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // A holds up to two entries; B takes a new one only if empty or draining
  function automatic logic exp_rdy(input int k);
    if (rst) return 1'b0;
    if (k == 0) return (msz[0] < 2);
    return (msz[1] == 0) || ordy;
  endfunction

  task automatic drv(input logic v, input logic [7:0] d, input logic r,
                     input logic f, input logic rs);
    iv = v; id = d; ordy = r; fl = f; rst = rs;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model update on every rising edge
  initial forever begin
    @(posedge clk);
    mr[0] = exp_rdy(0);
    mr[1] = exp_rdy(1);
    if (rst) begin
      model_on = 1'b1;
      for (int k = 0; k < 2; k++) begin
        msz[k]  = 0;
        mcnt[k] = 0;
      end
    end else if (model_on) begin
      for (int k = 0; k < 2; k++) begin
        if (msz[k] > 0 && !ordy && !fl && mcnt[k] < 15) mcnt[k]++;
        if (fl) begin
          msz[k] = 0;
        end else begin
          if (msz[k] > 0 && ordy) begin
            mq[k][0] = mq[k][1];
            msz[k]--;
          end
          if (iv && mr[k]) begin
            mq[k][msz[k]] = id;
            msz[k]++;
          end
        end
      end
    end
  end

  // compare DUT outputs with the model every falling edge
  initial forever begin
    @(negedge clk);
    if (model_on) begin
      chk("a_valid", 32'(a_ov), (msz[0] > 0) ? 32'd1 : 32'd0);
      chk("b_valid", 32'(b_ov), (msz[1] > 0) ? 32'd1 : 32'd0);
      if (msz[0] > 0) chk("a_data", 32'(a_od), 32'(mq[0][0]));
      if (msz[1] > 0) chk("b_data", 32'(b_od), 32'(mq[1][0]));
      chk("a_ready", 32'(a_ir), 32'(exp_rdy(0)));
      chk("b_ready", 32'(b_ir), 32'(exp_rdy(1)));
      chk("a_stall", 32'(a_sc), 32'(mcnt[0]));
      chk("b_stall", 32'(b_sc), 32'(mcnt[1]));
    end
  end

  initial begin
    drv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    chk("rst_a_valid", 32'(a_ov), 32'd0);
    chk("rst_a_data", 32'(a_od), 32'd0);
    chk("rst_a_ready", 32'(a_ir), 32'd0);
    chk("rst_b_ready", 32'(b_ir), 32'd0);
    chk("rst_a_stall", 32'(a_sc), 32'd0);
    drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    #1 chk("post_rst_a_ready", 32'(a_ir), 32'd1);

    // streaming at full rate
    drv(1'b1, 8'h11, 1'b1, 1'b0, 1'b0); tick();
    chk("stream_valid", 32'(a_ov), 32'd1);
    chk("stream_d0", 32'(a_od), 32'h11);
    drv(1'b1, 8'h22, 1'b1, 1'b0, 1'b0); tick();
    chk("stream_d1", 32'(a_od), 32'h22);
    drv(1'b1, 8'h33, 1'b1, 1'b0, 1'b0); tick();
    chk("stream_d2", 32'(a_od), 32'h33);
    drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); tick();
    chk("stream_drained", 32'(a_ov), 32'd0);
    chk("stream_stall", 32'(a_sc), 32'd0);

    // fill under back-pressure, then release
    drv(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0); tick();
    chk("bp_ready_after_1", 32'(a_ir), 32'd1);
    drv(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0); tick();
    chk("bp_ready_after_2", 32'(a_ir), 32'd0);
    chk("bp_head", 32'(a_od), 32'hA1);
    drv(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0); tick(); tick();
    chk("bp_stall3", 32'(a_sc), 32'd3);
    drv(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0); tick();
    chk("bp_order_a2", 32'(a_od), 32'hA2);
    chk("bp_ready_back", 32'(a_ir), 32'd1);
    tick();
    chk("bp_order_a3", 32'(a_od), 32'hA3);
    drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); tick();
    chk("bp_empty", 32'(a_ov), 32'd0);
    chk("bp_stall_final", 32'(a_sc), 32'd3);

    // flush while full, with a payload offered in the same cycle
    drv(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0); tick();
    drv(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0); tick();
    chk("fl_full_ready", 32'(a_ir), 32'd0);
    drv(1'b1, 8'hBB, 1'b0, 1'b1, 1'b0); tick();
    chk("fl_valid", 32'(a_ov), 32'd0);
    chk("fl_data_zero", 32'(a_od), 32'd0);
    chk("fl_ready", 32'(a_ir), 32'd1);
    chk("fl_b_valid", 32'(b_ov), 32'd0);
    chk("fl_b_data_kept", 32'(b_od), 32'hC1);
    chk("fl_stall_no_inc", 32'(a_sc), 32'd4);
    drv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick();
    chk("fl_no_bb", 32'(a_ov), 32'd0);

    // single-register back-to-back transfer
    drv(1'b1, 8'h04, 1'b0, 1'b0, 1'b0); tick();
    chk("b2b_blocked", 32'(b_ir), 32'd0);
    drv(1'b1, 8'h05, 1'b1, 1'b0, 1'b0);
    #1 chk("b2b_comb_ready", 32'(b_ir), 32'd1);
    tick();
    chk("b2b_valid", 32'(b_ov), 32'd1);
    chk("b2b_data", 32'(b_od), 32'h05);
    drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0); tick();

    // stall counter saturation, then reset clears it
    drv(1'b1, 8'h77, 1'b0, 1'b0, 1'b0); tick();
    drv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (20) tick();
    chk("sat_a", 32'(a_sc), 32'd15);
    chk("sat_b", 32'(b_sc), 32'd15);
    drv(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    #1 chk("rst_forces_ready", 32'(a_ir), 32'd0);
    tick();
    chk("sat_cleared_a", 32'(a_sc), 32'd0);
    chk("sat_cleared_b", 32'(b_sc), 32'd0);

    // reset together with flush while full
    drv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); tick();
    drv(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0); tick();
    drv(1'b1, 8'hD2, 1'b0, 1'b0, 1'b0); tick();
    chk("rf_full", 32'(a_ir), 32'd0);
    drv(1'b1, 8'hD3, 1'b0, 1'b1, 1'b1); tick();
    chk("rf_a_valid", 32'(a_ov), 32'd0);
    chk("rf_a_data", 32'(a_od), 32'd0);
    chk("rf_a_ready", 32'(a_ir), 32'd0);
    chk("rf_b_valid", 32'(b_ov), 32'd0);
    chk("rf_b_data", 32'(b_od), 32'd0);
    chk("rf_stall", 32'(a_sc), 32'd0);
    drv(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1 chk("rf_ready_after", 32'(a_ir), 32'd1);

    // randomized traffic
    repeat (3000) begin
      drv(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 31) == 0), ($urandom_range(0, 255) == 0));
      tick();
    end
    drv(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
